// File: rtl/dsi_ctrl_pkg.sv
// Shared types and defaults for the DSI lane scheduler.
// Scheduler states, lane limit, default timing and pad byte.
package dsi_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLK_START,
    S_CLK_PRE,
    S_DATA_ACTIVE,
    S_DATA_DRAIN,
    S_CLK_POST,
    S_CLK_STOP
  } sched_state_t;

  localparam int LANES_MAX = 4;
  localparam int T_CLK_PRE_DEF = 8;
  localparam int T_CLK_POST_DEF = 16;
  localparam logic [7:0] PAD_BYTE_DEF = 8'h00;

endpackage

// File: rtl/dsi_lane_timer.sv
// Loadable 8-bit down counter that saturates at zero.
// One instance is shared by the clock-lane pre and post waits.
module dsi_lane_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_val,
  output logic       o_zero
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/dsi_lanes_scheduler.sv
// Sequences one DSI clock lane and LANES data lanes per packet.
// Define DSI_CLK_CONTINUOUS_EN to keep the clock lane in HS between packets.
module dsi_lanes_scheduler
  import dsi_ctrl_pkg::*;
#(
  parameter int         LANES      = 4,
  parameter int         T_CLK_PRE  = T_CLK_PRE_DEF,
  parameter int         T_CLK_POST = T_CLK_POST_DEF,
  parameter logic [7:0] PAD_BYTE   = PAD_BYTE_DEF
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               lines_enable,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [8*LANES-1:0] s_data,
  input  logic [2:0]         s_nbytes,
  input  logic               s_last,
  input  logic               s_lp,
  output logic               lane_lines_en,
  output logic               lane_mode_lp,
  output logic [LANES-1:0]   lane_start_rqst,
  output logic [LANES-1:0]   lane_fin_rqst,
  output logic [8*LANES-1:0] lane_data,
  input  logic [LANES-1:0]   lane_data_rqst,
  input  logic [LANES-1:0]   lane_active,
  output logic               clk_start_rqst,
  output logic               clk_fin_rqst,
  input  logic               clk_active,
  output logic               busy,
  output logic               underflow
);

  localparam logic [7:0] PRE_LD  = 8'(T_CLK_PRE - 1);
  localparam logic [7:0] POST_LD = 8'(T_CLK_POST - 1);

  sched_state_t r_state;
  sched_state_t w_next;
  logic         r_lines_en;
  logic         r_lp;

  logic         w_on;
  logic         w_leave;
  logic         w_tmr_load;
  logic [7:0]   w_tmr_val;
  logic         w_tmr_zero;
  logic         w_ready;
  logic         w_uflow;
  logic         w_clk_start;
  logic         w_clk_fin;
  logic         w_fin;
  logic         w_lanes_idle;
  logic [LANES-1:0]   w_lane_start;
  logic [8*LANES-1:0] w_data;

  dsi_lane_timer u_tmr (
    .clk    (clk_sys),
    .rst    (rst),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_zero (w_tmr_zero)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lines_en <= 1'b0;
      r_lp       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_lines_en <= lines_enable;
        r_lp       <= w_leave & s_lp;
      end
    end
  end

  // LP packets only ever start lane 0, so only lane 0 gates the drain.
  assign w_lanes_idle = r_lp ? !lane_active[0] : (lane_active == '0);

  always_comb begin
    w_next       = r_state;
    w_leave      = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_ready      = 1'b0;
    w_uflow      = 1'b0;
    w_clk_start  = 1'b0;
    w_clk_fin    = 1'b0;
    w_fin        = 1'b0;
    w_lane_start = '0;
    unique case (r_state)
      S_IDLE: begin
`ifdef DSI_CLK_CONTINUOUS_EN
        if (!lines_enable && clk_active) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = POST_LD;
          w_next     = S_CLK_POST;
        end else if (lines_enable && !clk_active) begin
          w_clk_start = 1'b1;
          w_next      = S_CLK_START;
        end else if (lines_enable && s_valid) begin
          w_leave = 1'b1;
          w_next  = S_DATA_ACTIVE;
          if (s_lp) begin
            w_lane_start[0] = 1'b1;
          end else begin
            w_lane_start = '1;
          end
        end
`else
        if (lines_enable && s_valid) begin
          w_leave = 1'b1;
          if (s_lp) begin
            w_lane_start[0] = 1'b1;
            w_next          = S_DATA_ACTIVE;
          end else begin
            w_clk_start = 1'b1;
            w_next      = S_CLK_START;
          end
        end
`endif
      end
      S_CLK_START: begin
        if (clk_active) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = PRE_LD;
          w_next     = S_CLK_PRE;
        end
      end
      S_CLK_PRE: begin
        if (w_tmr_zero) begin
`ifdef DSI_CLK_CONTINUOUS_EN
          w_next = S_IDLE;
`else
          w_lane_start = '1;
          w_next       = S_DATA_ACTIVE;
`endif
        end
      end
      S_DATA_ACTIVE: begin
        if (lane_data_rqst[0]) begin
          if (s_valid) begin
            w_ready = 1'b1;
            if (s_last) begin
              w_fin  = 1'b1;
              w_next = S_DATA_DRAIN;
            end
          end else begin
            w_uflow = 1'b1;
          end
        end
      end
      S_DATA_DRAIN: begin
        if (w_lanes_idle) begin
`ifdef DSI_CLK_CONTINUOUS_EN
          w_next = S_IDLE;
`else
          if (r_lp) begin
            w_next = S_IDLE;
          end else begin
            w_tmr_load = 1'b1;
            w_tmr_val  = POST_LD;
            w_next     = S_CLK_POST;
          end
`endif
        end
      end
      S_CLK_POST: begin
        if (w_tmr_zero) begin
          w_clk_fin = 1'b1;
          w_next    = S_CLK_STOP;
        end
      end
      S_CLK_STOP: begin
        w_clk_fin = 1'b1;
        if (!clk_active) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_data = {LANES{PAD_BYTE}};
    if (r_state == S_DATA_ACTIVE && s_valid) begin
      for (int i = 0; i < LANES; i++) begin
        if (!(s_last && (3'(i) >= s_nbytes))) begin
          w_data[8*i +: 8] = s_data[8*i +: 8];
        end
      end
    end
  end

  // Mealy outputs are held quiet while reset is asserted.
  assign w_on            = !rst;
  assign s_ready         = w_on & w_ready;
  assign underflow       = w_on & w_uflow;
  assign clk_start_rqst  = w_on & w_clk_start;
  assign clk_fin_rqst    = w_on & w_clk_fin;
  assign lane_start_rqst = w_on ? w_lane_start : '0;
  assign lane_fin_rqst   = {LANES{w_on & w_fin}};
  assign lane_data       = w_on ? w_data : {LANES{PAD_BYTE}};
  assign lane_mode_lp    = w_on &
    ((r_state == S_IDLE) ? (w_leave & s_lp) : r_lp);
  assign lane_lines_en   = r_lines_en;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_dsi_lanes_scheduler.sv
// Directed bench for dsi_lanes_scheduler with a byte/fin scoreboard.
// Default build only (DSI_CLK_CONTINUOUS_EN undefined).
module tb_dsi_lanes_scheduler;

  localparam int LANES = 4;
  localparam int PRE   = 8;
  localparam int POST  = 16;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        lines_enable = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic [2:0]  s_nbytes = 3'd4;
  logic        s_last = 1'b0;
  logic        s_lp = 1'b0;
  logic [3:0]  lane_data_rqst = '0;
  logic [3:0]  lane_active = '0;
  logic        clk_active = 1'b0;

  logic        s_ready;
  logic        lane_lines_en;
  logic        lane_mode_lp;
  logic [3:0]  lane_start_rqst;
  logic [3:0]  lane_fin_rqst;
  logic [31:0] lane_data;
  logic        clk_start_rqst;
  logic        clk_fin_rqst;
  logic        busy;
  logic        underflow;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  f;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  dsi_lanes_scheduler #(
    .LANES(LANES), .T_CLK_PRE(PRE), .T_CLK_POST(POST), .PAD_BYTE(8'h00)
  ) dut (
    .clk_sys(clk_sys), .rst(rst), .lines_enable(lines_enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_nbytes(s_nbytes), .s_last(s_last), .s_lp(s_lp),
    .lane_lines_en(lane_lines_en), .lane_mode_lp(lane_mode_lp),
    .lane_start_rqst(lane_start_rqst), .lane_fin_rqst(lane_fin_rqst),
    .lane_data(lane_data), .lane_data_rqst(lane_data_rqst),
    .lane_active(lane_active), .clk_start_rqst(clk_start_rqst),
    .clk_fin_rqst(clk_fin_rqst), .clk_active(clk_active),
    .busy(busy), .underflow(underflow)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic look;
    #3;
  endtask

  task automatic word(input logic [31:0] d, input logic last,
                      input logic [2:0] nb, input logic [3:0] rq);
    exp_t e;
    tick;
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    s_nbytes = nb;
    lane_data_rqst = rq;
    e.d = d;
    if (last)
      for (int i = 0; i < 4; i++)
        if (i >= int'(nb)) e.d[8*i +: 8] = 8'h00;
    e.f = last ? 4'hF : 4'h0;
    sb.push_back(e);
    look;
    chk("s_ready", s_ready, 1);
    chk("no_underflow", underflow, 0);
    if (lane_data_rqst[0] && sb.size() > 0) begin
      e = sb.pop_front();
      chk("lane_data", lane_data, e.d);
      chk("lane_fin", lane_fin_rqst, e.f);
    end
  endtask

  task automatic hs_open(input logic [31:0] d0);
    tick;
    lines_enable = 1'b1;
    s_valid = 1'b1;
    s_data = d0;
    s_last = 1'b0;
    s_lp = 1'b0;
    clk_active = 1'b0;
    lane_data_rqst = '0;
    look;
    chk("clk_start", clk_start_rqst, 1);
    chk("ready_idle", s_ready, 0);
    tick;
    look;
    chk("busy", busy, 1);
    chk("clk_start_once", clk_start_rqst, 0);
    chk("lines_en", lane_lines_en, 1);
    chk("ready_clkstart", s_ready, 0);
    tick;
    clk_active = 1'b1;
    look;
    chk("no_start", lane_start_rqst, 0);
    for (int k = 1; k < PRE; k++) begin
      tick;
      look;
      chk("pre_wait", lane_start_rqst, 0);
    end
    tick;
    look;
    chk("lane_start", lane_start_rqst, 4'hF);
    chk("ready_pre", s_ready, 0);
  endtask

  task automatic hs_close;
    tick;
    s_valid = 1'b0;
    s_last = 1'b0;
    lane_data_rqst = '0;
    lane_active = 4'hF;
    look;
    chk("drain_busy", busy, 1);
    chk("drain_nofin", clk_fin_rqst, 0);
    tick;
    lane_active = 4'h0;
    look;
    chk("post_nofin", clk_fin_rqst, 0);
    for (int k = 1; k < POST; k++) begin
      tick;
      look;
      chk("post_wait", clk_fin_rqst, 0);
    end
    tick;
    look;
    chk("clk_fin", clk_fin_rqst, 1);
    tick;
    look;
    chk("clk_fin_lvl", clk_fin_rqst, 1);
    chk("stop_busy", busy, 1);
    tick;
    clk_active = 1'b0;
    look;
    chk("clk_fin_end", clk_fin_rqst, 1);
    tick;
    look;
    chk("idle_busy", busy, 0);
    chk("idle_nofin", clk_fin_rqst, 0);
  endtask

  initial begin
    // reset
    repeat (2) tick;
    look;
    chk("rst_busy", busy, 0);
    chk("rst_data", lane_data, 32'h0);
    chk("rst_start", lane_start_rqst, 0);
    chk("rst_clkstart", clk_start_rqst, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_linesen", lane_lines_en, 0);
    rst = 1'b0;

    // HS, 3 full words, lines_enable dropped mid-packet
    hs_open(32'h11223344);
    lines_enable = 1'b0;
    word(32'h11223344, 1'b0, 3'd4, 4'hF);
    word(32'h55667788, 1'b0, 3'd4, 4'hF);
    word(32'h99AABBCC, 1'b1, 3'd4, 4'hF);
    chk("lines_en_hold", lane_lines_en, 1);
    hs_close;
    tick;
    look;
    chk("lines_en_off", lane_lines_en, 0);

    // HS with 2 underflows and a short last word
    hs_open(32'hA1A2A3A4);
    word(32'hA1A2A3A4, 1'b0, 3'd4, 4'hF);
    for (int k = 0; k < 2; k++) begin
      tick;
      s_valid = 1'b0;
      look;
      chk("underflow", underflow, 1);
      chk("uflow_pad", lane_data, 32'h0);
      chk("uflow_nofin", lane_fin_rqst, 0);
      chk("uflow_ready", s_ready, 0);
    end
    word(32'hB1B2B3B4, 1'b0, 3'd4, 4'hF);
    word(32'hC1C2C3C4, 1'b1, 3'd2, 4'hF);
    hs_close;

    // LP single word
    tick;
    lines_enable = 1'b1;
    s_valid = 1'b1;
    s_lp = 1'b1;
    s_last = 1'b1;
    s_nbytes = 3'd1;
    s_data = 32'hDEADBEEF;
    look;
    chk("lp_start", lane_start_rqst, 4'b0001);
    chk("lp_noclk", clk_start_rqst, 0);
    chk("lp_mode", lane_mode_lp, 1);
    word(32'hDEADBEEF, 1'b1, 3'd1, 4'b0001);
    chk("lp_mode_act", lane_mode_lp, 1);
    chk("lp_noclk2", clk_start_rqst, 0);
    tick;
    s_valid = 1'b0;
    s_lp = 1'b0;
    lane_data_rqst = '0;
    lane_active = 4'b0001;
    look;
    chk("lp_drain", busy, 1);
    tick;
    lane_active = 4'b0110;
    look;
    tick;
    lane_active = 4'b0000;
    look;
    chk("lp_idle", busy, 0);
    chk("lp_nofin", clk_fin_rqst, 0);
    chk("lp_mode_off", lane_mode_lp, 0);

    // reset while in DATA_ACTIVE
    tick;
    s_valid = 1'b1;
    s_lp = 1'b1;
    s_last = 1'b1;
    s_nbytes = 3'd1;
    look;
    tick;
    rst = 1'b1;
    lane_data_rqst = 4'b0001;
    look;
    chk("rst_gate_ready", s_ready, 0);
    tick;
    look;
    chk("rst2_busy", busy, 0);
    chk("rst2_start", lane_start_rqst, 0);
    chk("rst2_fin", lane_fin_rqst, 0);
    chk("rst2_clkstart", clk_start_rqst, 0);
    chk("rst2_linesen", lane_lines_en, 0);
    tick;
    rst = 1'b0;
    s_valid = 1'b0;
    s_lp = 1'b0;
    lane_data_rqst = '0;
    look;

    // single-word HS packet after reset
    hs_open(32'h0BADF00D);
    word(32'h0BADF00D, 1'b1, 3'd3, 4'hF);
    hs_close;
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
